decomp_byte_packer: RTL and testbench



---
 rtl/decomp_byte_packer.sv | 167 ++++++++++++++++
 tb/tb_decomp_byte_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_byte_packer.sv
// Packs the decompressor's byte stream into WORD_BYTES-wide words, with a small FWFT output FIFO,
// flush of a final partial word on the first flush_req rising edge, and sticky loss reporting.
module decomp_byte_packer #(
    parameter int WORD_BYTES = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    in_byte,
    input  logic                          in_valid,
    input  logic                          flush_req,
    output logic [WORD_BYTES-1:0][7:0]    out_word,
    output logic [$clog2(WORD_BYTES):0]   out_count,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [31:0]                   byte_total,
    output logic                          done
);
    localparam int CW = $clog2(WORD_BYTES) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]                 state;
    logic [WORD_BYTES-1:0][7:0] lanes;
    logic [WORD_BYTES-1:0][7:0] cap_word;
    logic [WORD_BYTES-1:0][7:0] hold_word;
    logic [WORD_BYTES-1:0][7:0] push_word;
    logic [CW-1:0]              fill;
    logic [CW-1:0]              cap_count;
    logic [CW-1:0]              hold_count;
    logic [CW-1:0]              push_count;
    logic                       push_last;
    logic                       push_en;
    logic                       push_ok;
    logic                       pop;
    logic                       full;
    logic                       byte_in;
    logic                       flush_edge;
    logic                       word_done;
    logic                       flush_q;

    logic [WORD_BYTES-1:0][7:0] fifo_word  [FIFO_DEPTH];
    logic [CW-1:0]              fifo_count [FIFO_DEPTH];
    logic                       fifo_last  [FIFO_DEPTH];
    logic [PW-1:0]              rd_ptr;
    logic [PW-1:0]              wr_ptr;
    logic [PW:0]                level;

    assign out_valid  = (level != '0);
    assign pop        = out_valid && out_ready;
    assign full       = (level == (PW+1)'(FIFO_DEPTH));
    assign push_ok    = !full || pop;
    assign byte_in    = (state == ST_FILL) && in_valid;
    assign flush_edge = (state == ST_FILL) && flush_req && !flush_q;
    assign word_done  = byte_in && !flush_edge && (fill == CW'(WORD_BYTES - 1));
    assign cap_count  = fill + {{(CW-1){1'b0}}, byte_in};

    // The word as it stands after this cycle's byte; lanes beyond fill are always zero.
    always_comb begin
        cap_word = lanes;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_in && (fill == CW'(i))) begin
                cap_word[i] = in_byte;
            end
        end
    end

    // The held final word takes the single push slot in FLUSH; otherwise only a full word pushes.
    always_comb begin
        push_en    = 1'b0;
        push_word  = cap_word;
        push_count = CW'(WORD_BYTES);
        push_last  = 1'b0;
        if (state == ST_FLUSH) begin
            push_en    = 1'b1;
            push_word  = hold_word;
            push_count = hold_count;
            push_last  = 1'b1;
        end else if (word_done) begin
            push_en = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_FILL;
            lanes      <= '0;
            fill       <= '0;
            hold_word  <= '0;
            hold_count <= '0;
            flush_q    <= 1'b0;
            overflow   <= 1'b0;
            byte_total <= '0;
        end else begin
            flush_q <= flush_req;
            if (byte_in) begin
                byte_total <= byte_total + 32'd1;
            end
            if ((in_valid && (state != ST_FILL)) || (word_done && !push_ok)) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_FILL: begin
                    if (flush_edge) begin
                        hold_word  <= cap_word;
                        hold_count <= cap_count;
                        lanes      <= '0;
                        fill       <= '0;
                        state      <= ST_FLUSH;
                    end else if (word_done) begin
                        lanes <= '0;
                        fill  <= '0;
                    end else if (byte_in) begin
                        lanes <= cap_word;
                        fill  <= cap_count;
                    end
                end
                ST_FLUSH: begin
                    if (push_ok) begin
                        state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_en && push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if ((push_en && push_ok) && !pop) begin
                level <= level + (PW+1)'(1);
            end else if (!(push_en && push_ok) && pop) begin
                level <= level - (PW+1)'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push_en && push_ok) begin
            fifo_word[wr_ptr]  <= push_word;
            fifo_count[wr_ptr] <= push_count;
            fifo_last[wr_ptr]  <= push_last;
        end
    end

    assign out_word  = out_valid ? fifo_word[rd_ptr]  : '0;
    assign out_count = out_valid ? fifo_count[rd_ptr] : '0;
    assign out_last  = out_valid ? fifo_last[rd_ptr]  : 1'b0;
    assign done      = (state == ST_DONE) && (level == '0);

endmodule

// File: tb/tb_decomp_byte_packer.sv
// Scoreboard bench for decomp_byte_packer: directed byte streams queue expected words,
// and a negedge monitor compares every popped word against the queue head.
module tb_decomp_byte_packer;
    typedef logic [15:0][7:0] word_t;
    typedef struct packed {
        word_t      word;
        logic [4:0] count;
        logic       last;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        flush_req = 1'b0;
    word_t       out_word;
    logic [4:0]  out_count;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        overflow;
    logic [31:0] byte_total;
    logic        done;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    decomp_byte_packer #(.WORD_BYTES(16), .FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .flush_req  (flush_req),
        .out_word   (out_word),
        .out_count  (out_count),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .byte_total (byte_total),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic word_t make_word(input logic [7:0] start, input int n);
        word_t w = '0;
        for (int i = 0; i < n; i++) begin
            w[i] = start + 8'(i);
        end
        return w;
    endfunction

    task automatic expectWord(input logic [7:0] start, input int n, input logic last);
        exp_t e;
        e.word  = make_word(start, n);
        e.count = 5'(n);
        e.last  = last;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendRun(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(start + 8'(i));
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_word"}, out_word, 0);
        checkOutput({tag, "_count"}, out_count, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_total"}, byte_total, 0);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        flush_req = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        stepCycles(2);
        checkIdleOutputs("reset");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            stepCycles(1);
            k++;
        end
        checkOutput(name, exp_q.size(), 0);
        stepCycles(2);
    endtask

    // Every accepted head is compared against the oldest outstanding expectation.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got %h count %0d last %0d, expected no word",
                         out_word, out_count, out_last);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pop_word", out_word, e.word);
                checkOutput("pop_count", out_count, e.count);
                checkOutput("pop_last", out_last, e.last);
            end
        end
    end

    initial begin
        // Basic packing of two full words
        doReset();
        expectWord(8'h00, 16, 1'b0);
        expectWord(8'h10, 16, 1'b0);
        sendRun(8'h00, 32);
        waitDrain("basic_drain", 20);
        checkOutput("basic_total", byte_total, 32);
        checkOutput("basic_overflow", overflow, 0);
        checkOutput("basic_idle_word", out_word, 0);

        // Partial flush, then a late byte after DONE
        doReset();
        expectWord(8'hA1, 5, 1'b1);
        sendRun(8'hA1, 5);
        flush_req = 1'b1;
        waitDrain("partial_drain", 20);
        checkOutput("partial_done", done, 1);
        checkOutput("partial_total", byte_total, 5);
        applyStimulus(8'h77);
        stepCycles(1);
        checkOutput("late_overflow", overflow, 1);
        checkOutput("late_total", byte_total, 5);

        // Flush edge on the same cycle as the 16th byte
        doReset();
        expectWord(8'h20, 16, 1'b1);
        sendRun(8'h20, 15);
        in_byte   = 8'h2F;
        in_valid  = 1'b1;
        flush_req = 1'b1;
        stepCycles(1);
        in_valid = 1'b0;
        waitDrain("coinc_drain", 20);
        stepCycles(3);
        checkOutput("coinc_done", done, 1);
        checkOutput("coinc_total", byte_total, 16);

        // Flush with an empty assembly register yields a zero word
        doReset();
        expectWord(8'h30, 16, 1'b0);
        expectWord(8'h00, 0, 1'b1);
        sendRun(8'h30, 16);
        flush_req = 1'b1;
        waitDrain("empty_flush_drain", 20);
        checkOutput("empty_flush_done", done, 1);

        // Backpressure: five words into a four-deep FIFO
        doReset();
        out_ready = 1'b0;
        expectWord(8'h40, 16, 1'b0);
        expectWord(8'h50, 16, 1'b0);
        expectWord(8'h60, 16, 1'b0);
        expectWord(8'h70, 16, 1'b0);
        sendRun(8'h40, 80);
        checkOutput("bp_overflow", overflow, 1);
        checkOutput("bp_total", byte_total, 80);
        checkOutput("bp_valid", out_valid, 1);
        checkOutput("bp_head", out_word, make_word(8'h40, 16));
        expectWord(8'h00, 0, 1'b1);
        flush_req = 1'b1;
        stepCycles(5);
        checkOutput("bp_flush_wait", done, 0);
        checkOutput("bp_head_stable", out_word, make_word(8'h40, 16));
        out_ready = 1'b1;
        waitDrain("bp_drain", 30);
        checkOutput("bp_done", done, 1);

        // Reset in the middle of a word, then a clean word from lane 0
        doReset();
        sendRun(8'h55, 7);
        reset = 1'b1;
        #2;
        checkIdleOutputs("midreset");
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        expectWord(8'h90, 16, 1'b0);
        sendRun(8'h90, 16);
        waitDrain("midreset_drain", 20);
        checkOutput("midreset_total", byte_total, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
